// File: rtl/lrsc_resv_table.sv
// Multi-channel LR/SC reservation table: one granule-tagged reservation per channel.
// Define RESV_TIMEOUT_EN to add per-channel forward-progress timeout counters.
module lrsc_resv_table #(
    parameter int unsigned PA_BITS   = 56,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned GRAN_LOG2 = 6,
    parameter int unsigned TIMEOUT   = 255,
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               StallW,
    input  logic               FlushM,
    input  logic               ReqValidM,
    input  logic [CH_W-1:0]    ReqChM,
    input  logic [2:0]         ReqOpM,
    input  logic [PA_BITS-1:0] PAdrM,
    input  logic               SnoopValid,
    input  logic [PA_BITS-1:0] SnoopAdr,
    output logic               MemWriteEnM,
    output logic               SCFailW,
    output logic [CH_W-1:0]    SCChW,
    output logic [NUM_CH-1:0]  ResvValid
);

    localparam int unsigned TAG_W = PA_BITS - GRAN_LOG2;

    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_LR    = 3'b010;
    localparam logic [2:0] OP_SC    = 3'b011;
    localparam logic [2:0] OP_AMO   = 3'b100;

    logic [TAG_W-1:0] tag_q [NUM_CH];
    logic [TAG_W-1:0] tag_d [NUM_CH];
    logic [NUM_CH-1:0] valid_d;
    logic              sc_fail_d;
    logic [CH_W-1:0]   sc_ch_d;

    logic [TAG_W-1:0] req_tag;
    logic [TAG_W-1:0] snoop_tag;
    logic [CH_W-1:0]  ch;
    logic             ch_ok;
    logic             is_store, is_lr, is_sc, is_amo;
    logic             own_hit, snoop_kill;
    logic             commit, lr_commit, sc_commit, wr_commit;

    // Sub-granule address bits never take part in tag compares.
    logic unused_bits;
    assign unused_bits = ^{PAdrM[GRAN_LOG2-1:0], SnoopAdr[GRAN_LOG2-1:0]};

    assign req_tag   = PAdrM[PA_BITS-1:GRAN_LOG2];
    assign snoop_tag = SnoopAdr[PA_BITS-1:GRAN_LOG2];
    assign ch        = (NUM_CH == 1) ? '0 : ReqChM;
    assign ch_ok     = (32'(ch) < NUM_CH);

    assign is_store = (ReqOpM == OP_STORE);
    assign is_lr    = (ReqOpM == OP_LR);
    assign is_sc    = (ReqOpM == OP_SC);
    assign is_amo   = (ReqOpM == OP_AMO);

    assign own_hit    = ch_ok && ResvValid[ch] && (tag_q[ch] == req_tag);
    assign snoop_kill = SnoopValid && (snoop_tag == req_tag);

    // A snoop to the same granule beats an SC presented in the same cycle.
    assign MemWriteEnM = ReqValidM && !FlushM &&
                         (is_store || is_amo || (is_sc && own_hit && !snoop_kill));

    assign commit    = ReqValidM && !FlushM && !StallW;
    assign lr_commit = commit && is_lr && ch_ok;
    assign sc_commit = commit && is_sc;
    assign wr_commit = commit && MemWriteEnM;

`ifdef RESV_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_d [NUM_CH];
`else
    logic unused_timeout;
    assign unused_timeout = ^{32'(TIMEOUT)};
`endif

    // Next-state table: snoop/timeout/conflict clears first, LR set last so it wins.
    always_comb begin
        valid_d   = ResvValid;
        tag_d     = tag_q;
        sc_fail_d = SCFailW;
        sc_ch_d   = SCChW;
`ifdef RESV_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (!StallW) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (SnoopValid && (tag_q[k] == snoop_tag)) begin
                    valid_d[k] = 1'b0;
                end
`ifdef RESV_TIMEOUT_EN
                if (ResvValid[k]) begin
                    if (cnt_q[k] == CNT_LAST) begin
                        valid_d[k] = 1'b0;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_W'(1);
                    end
                end
`endif
                if (wr_commit && (CH_W'(k) != ch) && (tag_q[k] == req_tag)) begin
                    valid_d[k] = 1'b0;
                end
                if (sc_commit && (CH_W'(k) == ch)) begin
                    valid_d[k] = 1'b0;
                end
                if (lr_commit && (CH_W'(k) == ch)) begin
                    valid_d[k] = 1'b1;
                    tag_d[k]   = req_tag;
`ifdef RESV_TIMEOUT_EN
                    cnt_d[k]   = '0;
`endif
                end
            end
            if (sc_commit) begin
                sc_fail_d = !MemWriteEnM;
                sc_ch_d   = ch;
            end
        end
    end

    // Reservation and SC status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ResvValid <= '0;
            SCFailW   <= 1'b0;
            SCChW     <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            ResvValid <= valid_d;
            SCFailW   <= sc_fail_d;
            SCChW     <= sc_ch_d;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

`ifdef RESV_TIMEOUT_EN
    // Per-channel reservation age counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end
`endif

endmodule

// File: tb/tb_lrsc_resv_table.sv
// Scoreboard bench for lrsc_resv_table: directed LR/SC scenarios plus randomized traffic
// checked against a granule-level reference model.
module tb_lrsc_resv_table;

    localparam int unsigned PA_BITS   = 56;
    localparam int unsigned NUM_CH    = 4;
    localparam int unsigned GRAN_LOG2 = 6;
`ifdef RESV_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 4;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic               clk = 1'b0;
    logic               reset_n;
    logic               StallW, FlushM, ReqValidM;
    logic [1:0]         ReqChM;
    logic [2:0]         ReqOpM;
    logic [PA_BITS-1:0] PAdrM;
    logic               SnoopValid;
    logic [PA_BITS-1:0] SnoopAdr;
    logic               MemWriteEnM;
    logic               SCFailW;
    logic [1:0]         SCChW;
    logic [NUM_CH-1:0]  ResvValid;

    lrsc_resv_table #(
        .PA_BITS(PA_BITS), .NUM_CH(NUM_CH), .GRAN_LOG2(GRAN_LOG2), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .StallW(StallW), .FlushM(FlushM),
        .ReqValidM(ReqValidM), .ReqChM(ReqChM), .ReqOpM(ReqOpM), .PAdrM(PAdrM),
        .SnoopValid(SnoopValid), .SnoopAdr(SnoopAdr), .MemWriteEnM(MemWriteEnM),
        .SCFailW(SCFailW), .SCChW(SCChW), .ResvValid(ResvValid)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic mwe; } comb_t;
    typedef struct { int cyc; logic [NUM_CH-1:0] valid; logic fail; logic [1:0] ch; } st_t;

    comb_t cq[$];
    st_t   sq[$];
    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;

    // Reference model: reservation = (valid, granule number, age in unstalled cycles).
    bit                 m_valid [NUM_CH];
    logic [PA_BITS-1:0] m_gran  [NUM_CH];
    int                 m_age   [NUM_CH];
    bit                 m_fail;
    int                 m_ch;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        comb_t c;
        st_t   s;
        if (cq.size() > 0 && cq[0].cyc == cyc) begin
            c = cq.pop_front();
            check("MemWriteEnM", 64'(MemWriteEnM), 64'(c.mwe));
        end
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
            s = sq.pop_front();
            check("ResvValid", 64'(ResvValid), 64'(s.valid));
            check("SCFailW", 64'(SCFailW), 64'(s.fail));
            check("SCChW", 64'(SCChW), 64'(s.ch));
        end
    end

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_valid[k] = 1'b0;
            m_gran[k]  = '0;
            m_age[k]   = 0;
        end
        m_fail = 1'b0;
        m_ch   = 0;
    endtask

    task automatic set_idle();
        ReqValidM = 1'b0; ReqChM = '0; ReqOpM = '0; PAdrM = '0;
        FlushM = 1'b0; StallW = 1'b0; SnoopValid = 1'b0; SnoopAdr = '0;
    endtask

    task automatic drive(input bit v, input int ch, input int op, input logic [PA_BITS-1:0] a,
                         input bit fl, input bit st, input bit sv, input logic [PA_BITS-1:0] sa);
        logic [PA_BITS-1:0] g, sg;
        bit own, kill, mwe, commit;
        bit nv [NUM_CH];
        logic [NUM_CH-1:0] vv;
        comb_t c;
        st_t   s;
        @(posedge clk);
        #1;
        ReqValidM = v; ReqChM = 2'(ch); ReqOpM = 3'(op); PAdrM = a;
        FlushM = fl; StallW = st; SnoopValid = sv; SnoopAdr = sa;
        g    = a >> GRAN_LOG2;
        sg   = sa >> GRAN_LOG2;
        own  = m_valid[ch] && (m_gran[ch] == g);
        kill = sv && (sg == g);
        mwe  = v && !fl && (op == 1 || op == 4 || (op == 3 && own && !kill));
        c.cyc = cyc; c.mwe = mwe;
        cq.push_back(c);
        if (!st) begin
            commit = v && !fl;
            for (int k = 0; k < NUM_CH; k++) begin
                nv[k] = m_valid[k];
                if (sv && m_gran[k] == sg) nv[k] = 1'b0;
`ifdef RESV_TIMEOUT_EN
                if (m_valid[k]) begin
                    if (m_age[k] >= TB_TIMEOUT - 1) nv[k] = 1'b0;
                    else m_age[k]++;
                end
`endif
                if (commit && mwe && k != ch && m_gran[k] == g) nv[k] = 1'b0;
            end
            if (commit && op == 3) begin
                nv[ch] = 1'b0;
                m_fail = !mwe;
                m_ch   = ch;
            end
            if (commit && op == 2) begin
                nv[ch]     = 1'b1;
                m_gran[ch] = g;
                m_age[ch]  = 0;
            end
            m_valid = nv;
        end
        for (int k = 0; k < NUM_CH; k++) vv[k] = m_valid[k];
        s.cyc = cyc; s.valid = vv; s.fail = m_fail; s.ch = 2'(m_ch);
        sq.push_back(s);
    endtask

    task automatic req(input int ch, input int op, input logic [PA_BITS-1:0] a);
        drive(1'b1, ch, op, a, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [PA_BITS-1:0] rand_adr();
        logic [PA_BITS-1:0] bases [4];
        bases[0] = 56'h1000;
        bases[1] = 56'h1040;
        bases[2] = 56'h2000;
        bases[3] = 56'h80_0000_0000_1000;
        return bases[$urandom_range(0, 3)] + PA_BITS'($urandom_range(0, 63));
    endfunction

    initial begin
        int r, op;
        set_idle();
        model_reset();
        reset_n = 1'b0;
        #1;
        check("reset_ResvValid", 64'(ResvValid), 64'h0);
        check("reset_SCFailW", 64'(SCFailW), 64'h0);
        check("reset_SCChW", 64'(SCChW), 64'h0);
        repeat (2) @(posedge clk);
        release_reset();

        // LR then SC in the same granule succeeds.
        req(0, 2, 56'h1000);
        req(0, 3, 56'h1020);
        idle(1);
        // Another channel's store kills the reservation.
        req(1, 2, 56'h2000);
        req(2, 1, 56'h203F);
        req(1, 3, 56'h2000);
        idle(1);
        // Snoop to the same granule beats the SC.
        req(0, 2, 56'h3000);
        drive(1'b1, 0, 3, 56'h3000, 1'b0, 1'b0, 1'b1, 56'h3008);
        idle(1);
        // Snoop and LR to the same granule together: LR wins.
        drive(1'b1, 2, 2, 56'h4000, 1'b0, 1'b0, 1'b1, 56'h4010);
        idle(1);
        // Flushed LR leaves the table alone; own store keeps the reservation.
        drive(1'b1, 0, 2, 56'h5000, 1'b1, 1'b0, 1'b0, '0);
        req(0, 2, 56'h5000);
        req(0, 1, 56'h5004);
        req(0, 4, 56'h5008);
        idle(1);
        // Stalled SC does not commit; same-tag bits above the granule must differ.
        req(1, 2, 56'h6000);
        drive(1'b1, 1, 3, 56'h6000, 1'b0, 1'b1, 1'b0, '0);
        req(3, 1, 56'h80_0000_0000_6000);
        req(1, 3, 56'h6000);
`ifdef RESV_TIMEOUT_EN
        req(3, 2, 56'h7000);
        idle(4);
        req(3, 3, 56'h7000);
        req(3, 2, 56'h7000);
        idle(2);
        for (int i = 0; i < 10; i++) drive(1'b0, 0, 0, '0, 1'b0, 1'b1, 1'b0, '0);
        req(3, 3, 56'h7000);
`endif

        // Reservation held and SCFailW=1, then asynchronous reset mid-cycle.
        req(2, 2, 56'h1000);
        req(1, 3, 56'h2000);
        idle(1);
        @(negedge clk);
        #1;
        set_idle();
        reset_n = 1'b0;
        #1;
        check("midreset_ResvValid", 64'(ResvValid), 64'h0);
        check("midreset_SCFailW", 64'(SCFailW), 64'h0);
        check("midreset_SCChW", 64'(SCChW), 64'h0);
        cq.delete();
        sq.delete();
        model_reset();
        release_reset();

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    op = 0;
                2:       op = 1;
                3, 4, 5: op = 2;
                6, 7:    op = 3;
                8:       op = 4;
                default: op = $urandom_range(5, 7);
            endcase
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 3), op, rand_adr(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
                  $urandom_range(0, 6) == 0, rand_adr());
        end
        idle(2);
        repeat (2) @(negedge clk);
        #1;
        check("scoreboard_drain", 64'(cq.size() + sq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
